// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and baud helper.
// Intended to be reused by the parametrised transmitter as well.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  function automatic int baud_period(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rx input conditioning: 2-FF synchroniser followed by a 3-tap majority voter.
// Every flop presets to 1 (line idle) so reset release never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_sync,
  output logic vote
);

  logic       sync1;
  logic       sync2;
  logic [2:0] taps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      taps  <= 3'b111;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      taps  <= {taps[1:0], sync2};
    end
  end

  assign rx_sync = sync2;
  assign vote    = (taps[0] & taps[1]) | (taps[0] & taps[2]) | (taps[1] & taps[2]);

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable data/parity/stop format, mid-bit majority
// sampling, error/break flags and a valid/ready output register with overrun pulse.
//
// state      | meaning
// IDLE       | waiting for synchronised rx low
// START      | confirming start bit at mid-bit (false start returns to IDLE)
// DATA       | shifting in DATA_BITS samples, LSB first
// PARITY     | sampling the parity bit
// STOP       | sampling STOP_BITS stop bits, frame completes at the last mid-sample
// WAIT_IDLE  | break seen, holding until the line returns high
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  input  logic                 rx_data_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int BAUD_PERIOD = baud_period(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CW          = $clog2(BAUD_PERIOD);

  rx_state_e            state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 zero_acc;
  logic                 ferr_acc;

  logic                 frm_done;
  logic [DATA_BITS-1:0] frm_data;
  logic                 frm_perr;
  logic                 frm_ferr;
  logic                 frm_brk;

  logic rx_sync;
  logic vote;
  logic mid;
  logic last;
  logic ferr_now;
  logic brk_now;
  logic perr_now;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_sync (rx_sync),
    .vote    (vote)
  );

  assign mid      = (cnt == CW'(BAUD_PERIOD / 2));
  assign last     = (cnt == CW'(BAUD_PERIOD - 1));
  assign ferr_now = ferr_acc | ~vote;
  assign brk_now  = zero_acc & ~vote;
  assign perr_now = (PARITY == PARITY_ODD)  ? ~par_acc :
                    (PARITY == PARITY_EVEN) ?  par_acc : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      zero_acc <= 1'b0;
      ferr_acc <= 1'b0;
      frm_done <= 1'b0;
      frm_data <= '0;
      frm_perr <= 1'b0;
      frm_ferr <= 1'b0;
      frm_brk  <= 1'b0;
    end else begin
      frm_done <= 1'b0;
      if (state != ST_IDLE) begin
        cnt <= last ? '0 : cnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (!rx_sync) begin
            cnt   <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (mid) begin
            if (vote) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_DATA;
              bit_cnt  <= '0;
              par_acc  <= 1'b0;
              zero_acc <= 1'b1;
              ferr_acc <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (mid) begin
            shreg    <= {vote, shreg[DATA_BITS-1:1]};
            par_acc  <= par_acc ^ vote;
            zero_acc <= brk_now;
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (mid) begin
            par_acc  <= par_acc ^ vote;
            zero_acc <= brk_now;
            bit_cnt  <= '0;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Completion is declared at the last stop mid-sample so back-to-back frames fit.
          if (mid) begin
            if (bit_cnt == 4'(STOP_BITS - 1)) begin
              frm_done <= 1'b1;
              frm_data <= shreg;
              frm_perr <= perr_now;
              frm_ferr <= ferr_now;
              frm_brk  <= brk_now;
              state    <= brk_now ? ST_WAIT_IDLE : ST_IDLE;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              ferr_acc <= ferr_now;
              zero_acc <= brk_now;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_sync) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (frm_done) begin
        // A word being consumed on this same edge frees the register for the new one.
        if (!rx_data_valid || rx_data_ready) begin
          rx_data       <= frm_data;
          rx_data_valid <= 1'b1;
          rx_parity_err <= frm_perr;
          rx_frame_err  <= frm_ferr;
          rx_break      <= frm_brk;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
        rx_parity_err <= 1'b0;
        rx_frame_err  <= 1'b0;
        rx_break      <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: default 8N1 at full rate, plus fast 8E1 and 7N2 instances.
module tb_uart_rx_cfg;

  localparam int BP_DEF  = 1250;
  localparam int BP_FAST = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rx_def = 1'b1, ready_def = 1'b1;
  logic [7:0] def_data;
  logic       def_valid, def_perr, def_ferr, def_brk, def_ov, def_busy;

  logic       rx_par = 1'b1, ready_par = 1'b1;
  logic [7:0] par_data;
  logic       par_valid, par_perr, par_ferr, par_brk, par_ov, par_busy;

  logic       rx_s2 = 1'b1, ready_s2 = 1'b0;
  logic [6:0] s2_data;
  logic       s2_valid, s2_perr, s2_ferr, s2_brk, s2_ov, s2_busy;

  uart_rx_cfg u_def (
    .clk(clk), .rst_n(rst_n), .rx(rx_def), .rx_data(def_data), .rx_data_valid(def_valid),
    .rx_data_ready(ready_def), .rx_parity_err(def_perr), .rx_frame_err(def_ferr),
    .rx_break(def_brk), .rx_overrun(def_ov), .rx_busy(def_busy)
  );

  uart_rx_cfg #(.CLK_FREQ_HZ(BP_FAST * 9600), .BAUD_RATE(9600), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(1)) u_par (
    .clk(clk), .rst_n(rst_n), .rx(rx_par), .rx_data(par_data), .rx_data_valid(par_valid),
    .rx_data_ready(ready_par), .rx_parity_err(par_perr), .rx_frame_err(par_ferr),
    .rx_break(par_brk), .rx_overrun(par_ov), .rx_busy(par_busy)
  );

  uart_rx_cfg #(.CLK_FREQ_HZ(BP_FAST * 9600), .BAUD_RATE(9600), .DATA_BITS(7),
                .PARITY(0), .STOP_BITS(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .rx(rx_s2), .rx_data(s2_data), .rx_data_valid(s2_valid),
    .rx_data_ready(ready_s2), .rx_parity_err(s2_perr), .rx_frame_err(s2_ferr),
    .rx_break(s2_brk), .rx_overrun(s2_ov), .rx_busy(s2_busy)
  );

  int errors = 0;
  int checks = 0;

  // Handshake monitors: record every accepted word and every overrun cycle.
  int       def_acc = 0, par_acc = 0, par_ov_cnt = 0, def_ov_cnt = 0;
  logic [7:0] def_last = '0, par_last = '0;
  logic [2:0] def_flags = '0, par_flags = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (def_valid && ready_def) begin
        def_acc++;
        def_last  = def_data;
        def_flags = {def_perr, def_ferr, def_brk};
      end
      if (par_valid && ready_par) begin
        par_acc++;
        par_last  = par_data;
        par_flags = {par_perr, par_ferr, par_brk};
      end
      if (par_ov) par_ov_cnt++;
      if (def_ov) def_ov_cnt++;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0:       rx_def = v;
      1:       rx_par = v;
      default: rx_s2  = v;
    endcase
  endtask

  task automatic send_bits(input int inst, input logic [15:0] bits, input int n, input int bp);
    for (int i = 0; i < n; i++) begin
      set_rx(inst, bits[i]);
      tick(bp);
    end
  endtask

  initial begin
    // Reset state
    tick(4);
    @(negedge clk);
    check("rst_def_valid", 16'(def_valid), 16'h0);
    check("rst_def_data", 16'(def_data), 16'h0);
    check("rst_def_flags", 16'({def_perr, def_ferr, def_brk, def_ov}), 16'h0);
    check("rst_def_busy", 16'(def_busy), 16'h0);
    check("rst_s2_data", 16'(s2_data), 16'h0);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    @(negedge clk);
    check("post_rst_busy", 16'({def_busy, par_busy, s2_busy}), 16'h0);

    // 1: 8N1 at 1250 clocks per bit, 0xFB
    send_bits(0, {6'b0, 1'b1, 8'hFB, 1'b0}, 10, BP_DEF);
    tick(100);
    @(negedge clk);
    check("t1_accepts", 16'(def_acc), 16'd1);
    check("t1_data", 16'(def_last), 16'h00FB);
    check("t1_flags", 16'(def_flags), 16'h0);
    check("t1_overrun", 16'(def_ov_cnt), 16'd0);

    // 2: 300-cycle glitch is a false start
    rx_def = 1'b0;
    tick(300);
    rx_def = 1'b1;
    tick(20);
    @(negedge clk);
    check("t2_busy_in_start", 16'(def_busy), 16'h1);
    tick(320);
    @(negedge clk);
    check("t2_busy_back_idle", 16'(def_busy), 16'h0);
    check("t2_no_valid", 16'(def_valid), 16'h0);
    check("t2_accepts", 16'(def_acc), 16'd1);

    // 3: even parity, 0x5A with wrong then correct parity bit
    send_bits(1, {5'b0, 1'b1, 1'b1, 8'h5A, 1'b0}, 11, BP_FAST);
    tick(32);
    @(negedge clk);
    check("t3_accepts_a", 16'(par_acc), 16'd1);
    check("t3_data_a", 16'(par_last), 16'h005A);
    check("t3_flags_a", 16'(par_flags), 16'b100);
    send_bits(1, {5'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 11, BP_FAST);
    tick(32);
    @(negedge clk);
    check("t3_accepts_b", 16'(par_acc), 16'd2);
    check("t3_data_b", 16'(par_last), 16'h005A);
    check("t3_flags_b", 16'(par_flags), 16'b000);

    // 4: line held low for 15 bit times is a break
    rx_par = 1'b0;
    tick(15 * BP_FAST);
    @(negedge clk);
    check("t4_accepts", 16'(par_acc), 16'd3);
    check("t4_data", 16'(par_last), 16'h0000);
    check("t4_flags", 16'(par_flags), 16'b011);
    check("t4_wait_idle_busy", 16'(par_busy), 16'h1);
    tick(1);
    rx_par = 1'b1;
    tick(3 * BP_FAST);
    @(negedge clk);
    check("t4_idle_after_break", 16'(par_busy), 16'h0);
    check("t4_no_second_frame", 16'(par_acc), 16'd3);
    send_bits(1, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, BP_FAST);
    tick(32);
    @(negedge clk);
    check("t4_next_accepts", 16'(par_acc), 16'd4);
    check("t4_next_data", 16'(par_last), 16'h003C);
    check("t4_next_flags", 16'(par_flags), 16'b000);

    // 5: overrun with ready low, 0x11 then 0x22 back-to-back
    tick(1);
    ready_par = 1'b0;
    send_bits(1, {5'b0, 1'b1, 1'b0, 8'h11, 1'b0}, 11, BP_FAST);
    send_bits(1, {5'b0, 1'b1, 1'b0, 8'h22, 1'b0}, 11, BP_FAST);
    tick(32);
    @(negedge clk);
    check("t5_overrun_pulses", 16'(par_ov_cnt), 16'd1);
    check("t5_valid_held", 16'(par_valid), 16'h1);
    check("t5_data_held", 16'(par_data), 16'h0011);
    tick(1);
    ready_par = 1'b1;
    tick(1);
    @(negedge clk);
    check("t5_valid_cleared", 16'(par_valid), 16'h0);
    check("t5_accepts", 16'(par_acc), 16'd5);
    check("t5_accepted_data", 16'(par_last), 16'h0011);

    // 6: 7N2 with second stop bit low, then reset mid-DATA
    tick(1);
    send_bits(2, {6'b0, 1'b0, 1'b1, 7'h55, 1'b0}, 10, BP_FAST);
    rx_s2 = 1'b1;
    tick(3 * BP_FAST);
    @(negedge clk);
    check("t6_valid", 16'(s2_valid), 16'h1);
    check("t6_data", 16'(s2_data), 16'h0055);
    check("t6_flags", 16'({s2_perr, s2_ferr, s2_brk}), 16'b010);
    tick(1);
    send_bits(2, 16'h0000, 2, BP_FAST);
    rx_s2 = 1'b0;
    tick(4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 16'(s2_valid), 16'h0);
    check("t6_rst_data", 16'(s2_data), 16'h0);
    check("t6_rst_flags", 16'({s2_perr, s2_ferr, s2_brk, s2_ov}), 16'h0);
    check("t6_rst_busy", 16'(s2_busy), 16'h0);
    tick(12);
    rx_s2 = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(8 * BP_FAST);
    @(negedge clk);
    check("t6_no_valid_after", 16'(s2_valid), 16'h0);
    check("t6_idle_after", 16'(s2_busy), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Supports 5–9 data bits, none/odd/even parity and 1 or 2 stop bits.
- Adds 3-sample majority voting at mid-bit, false-start rejection, parity/framing/break detection and a valid/ready output handshake with overrun flag.
- Sits between the board rx pin and the command/FIFO logic, in the same clock domain as the rest of the serial path.

Parameters:
CLK_FREQ_HZ, 12000000, system clock frequency.
BAUD_RATE, 9600, line rate. BAUD_PERIOD = CLK_FREQ_HZ/BAUD_RATE (integer divide), must be ≥ 8.
DATA_BITS, 8, data bits per frame, legal 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, legal 1 or 2.

Ports:
clk  in  1  system clock, all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
rx  in  1  asynchronous serial line, idle high.
rx_data  out  DATA_BITS  received word, LSB = first bit on the line.
rx_data_valid  out  1  high while rx_data holds an unconsumed word.
rx_data_ready  in  1  consumer accepts the word when valid & ready on a clk edge.
rx_parity_err  out  1  qualifies the current word; meaningful only while valid.
rx_frame_err  out  1  a stop bit was sampled low; qualifies the current word.
rx_break  out  1  qualifies the current word: all data bits, parity bit and stop bits were 0.
rx_overrun  out  1  one-cycle pulse when a frame completes while valid is still high.
rx_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, async):
  - FSM = IDLE; all outputs 0; rx_data = 0.
  - Synchroniser flops preset to 1, so no spurious start bit on reset release.
- Input path:
  - rx passes through a 2-FF synchroniser, then a 3-bit shift register of synchronised samples.
  - vote = majority of the 3 taps.
- Baud counter:
  - Counts 0..BAUD_PERIOD-1 and reloads on every bit boundary.
  - A sample is taken when the count reaches BAUD_PERIOD/2; vote is taken on that cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: when the synchronised rx is 0, clear the counter and go to START.
  - START: at mid-bit, vote = 1 returns to IDLE with no outputs (false start); vote = 0 goes to DATA.
  - DATA: shift vote in LSB-first at each mid-bit. After DATA_BITS samples go to PARITY, or to STOP if PARITY = 0.
  - PARITY: sample the parity bit. Error when the XOR of data and parity bit ≠ 1 (odd) or ≠ 0 (even).
  - STOP: sample STOP_BITS stop bits; frame_err if any is 0.
    - Frame complete one cycle after the mid-sample of the last stop bit.
    - Completion with break goes to WAIT_IDLE; otherwise to IDLE.
    - The FSM does not wait for the end of the stop bit, so back-to-back frames are accepted.
  - WAIT_IDLE: stay until synchronised rx = 1, then go to IDLE. No new frame is recognised while the line is held low.
- Output register:
  - On frame complete with valid = 0: load rx_data and the three error flags, set valid.
  - On frame complete with valid = 1 and ready = 0: pulse rx_overrun for 1 cycle. The new frame is dropped and the held word is unchanged.
  - Frame complete and valid & ready on the same edge: the new word loads and valid stays 1; no overrun.
  - valid & ready alone: clear valid on that edge.
  - Error flags clear together with valid.
- Latency: line falling edge to valid is 2 sync cycles + (1 + DATA_BITS + parity + STOP_BITS - 0.5) × BAUD_PERIOD + 2 cycles (±1).
- Reset mid-frame: immediate return to IDLE, partial word discarded. Any in-progress line activity after release is treated as a fresh start-bit search.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/ODD/EVEN localparams.
  - State enum encoding.
  - Function baud_period(clk, baud).
  - Shared later with the planned parametrised transmitter.
- One sub-module, uart_rx_sync: 2-FF synchroniser, 3-tap majority voter and vote output, reset preset to 1.
- FSM, counter and output register stay in uart_rx_cfg.

Test Plan:
1. Defaults (8N1, BAUD_PERIOD = 1250): send 0xFB LSB-first, ready held 1 → single valid cycle with rx_data = 0xFB, all error flags 0.
2. rx low for 300 cycles then high → no valid; busy high then low; FSM back in IDLE by the 626th cycle.
3. PARITY = 2, send 0x5A with the parity bit wrong (1) → valid with rx_data = 0x5A, rx_parity_err = 1. Repeat with the correct bit (0) → rx_parity_err = 0.
4. Hold rx low for 15 bit times → rx_break = 1, rx_frame_err = 1, rx_data = 0x00. No second frame until rx returns high and a new start bit arrives.
5. ready = 0, send 0x11 then 0x22 back-to-back → valid with 0x11, rx_overrun pulse at the end of the second frame. Raising ready then clears valid, and rx_data remains 0x11 until that handshake.
6. STOP_BITS = 2, DATA_BITS = 7, second stop bit forced 0 → rx_frame_err = 1. Also assert rst_n low mid-DATA of another frame → all outputs 0 at once, no valid after release.
